// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the LEGv8 pipeline front end.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int unsigned PC_W = 64;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Opcode field of the instruction word, consumed by the main decoder
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 21;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/imem.sv
`default_nettype none
// ============================================================================
// Module      : imem
// Description : Combinational instruction ROM; unlisted words read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module imem
    import core_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned AW         = $clog2(IMEM_WORDS)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);

    localparam int unsigned c_INIT_WORDS = 16;
    localparam logic [31:0] c_INIT [c_INIT_WORDS] = '{
        32'hF8400000, 32'hF8000000, 32'h8B000000, 32'hB4000000,
        32'hCB010000, 32'h91000421, 32'hAA020020, 32'h8A030040,
        32'hD2800101, 32'hF8408002, 32'hB5000060, 32'h17FFFFFF,
        32'h8B020023, 32'hCB030044, 32'hF8010005, 32'hD503201F
    };

    logic [31:0] w_rom [IMEM_WORDS];

    for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_rom
        if (i < c_INIT_WORDS) begin : g_init
            assign w_rom[i] = c_INIT[i];
        end else begin : g_zero
            assign w_rom[i] = NOP_INSTR;
        end
    end

    assign rdata = w_rom[addr];

endmodule : imem
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : IF stage - PC register, ROM fetch and IF/ID pipeline register
//               with load-use stall and taken-branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import core_pkg::*;
#(
    parameter int unsigned N          = 64,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         Stall,
    input  logic         PCSrc,
    input  logic [N-1:0] PCBranch,
    output logic [N-1:0] IF_ID_pc,
    output logic [31:0]  IF_ID_instr,
    output logic         IF_ID_valid
);

    localparam int unsigned c_AW = $clog2(IMEM_WORDS);

    logic [N-1:0]    r_pc;
    logic [N-1:0]    r_if_pc;
    logic [31:0]     r_if_instr;
    logic            r_if_valid;

    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_rom_data;
    logic            w_oob;
    logic [31:0]     w_fetched;
    logic [1:0]      w_unused_branch_lsbs;

    assign w_idx = r_pc[c_AW+1:2];
    // Addresses beyond the ROM fetch a NOP instead of aliasing into it
    assign w_oob = |r_pc[N-1:c_AW+2];
    assign w_fetched = w_oob ? NOP_INSTR : w_rom_data;
    assign w_unused_branch_lsbs = PCBranch[1:0];

    imem #(
        .IMEM_WORDS (IMEM_WORDS),
        .AW         (c_AW)
    ) u_imem (
        .addr  (w_idx),
        .rdata (w_rom_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= '0;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else if (PCSrc) begin
            // Redirect wins over a stall so a taken branch is never lost
            r_pc       <= {PCBranch[N-1:2], 2'b00};
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else if (!Stall) begin
            r_pc       <= r_pc + N'(4);
            r_if_pc    <= r_pc;
            r_if_instr <= w_fetched;
            r_if_valid <= 1'b1;
        end
    end

    assign IF_ID_pc    = r_if_pc;
    assign IF_ID_instr = r_if_instr;
    assign IF_ID_valid = r_if_valid;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed vector bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic [63:0] pcbranch = '0;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [63:0] br;
        logic [63:0] epc;
        logic [31:0] einstr;
        logic        evalid;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(
        .N          (64),
        .IMEM_WORDS (64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Stall       (stall),
        .PCSrc       (pcsrc),
        .PCBranch    (pcbranch),
        .IF_ID_pc    (if_id_pc),
        .IF_ID_instr (if_id_instr),
        .IF_ID_valid (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] epc,
                         input logic [31:0] einstr, input logic evalid);
        n_vec++;
        if (if_id_pc !== epc || if_id_instr !== einstr || if_id_valid !== evalid) begin
            n_err++;
            $display("FAIL %s: got pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
                     name, if_id_pc, if_id_instr, if_id_valid, epc, einstr, evalid);
        end
    endtask

    task automatic add(input logic s, input logic p, input logic [63:0] b,
                       input logic [63:0] epc, input logic [31:0] ei, input logic ev);
        vec_t v;
        v.stall = s; v.pcsrc = p; v.br = b;
        v.epc = epc; v.einstr = ei; v.evalid = ev;
        vecs.push_back(v);
    endtask

    initial begin
        // free run from reset
        add(0, 0, 64'h0,   64'h0,  32'hF8400000, 1);
        add(0, 0, 64'h0,   64'h4,  32'hF8000000, 1);
        add(0, 0, 64'h0,   64'h8,  32'h8B000000, 1);
        // three stalled edges hold IF/ID at pc=8
        add(1, 0, 64'h0,   64'h8,  32'h8B000000, 1);
        add(1, 0, 64'h0,   64'h8,  32'h8B000000, 1);
        add(1, 0, 64'h0,   64'h8,  32'h8B000000, 1);
        add(0, 0, 64'h0,   64'hC,  32'hB4000000, 1);
        // redirect while stalled: bubble, then target with low bits dropped
        add(1, 1, 64'h23,  64'h0,  32'h0,        0);
        add(0, 0, 64'h0,   64'h20, 32'hD2800101, 1);
        add(0, 0, 64'h0,   64'h24, 32'hF8408002, 1);
        // stall during the bubble keeps the bubble
        add(0, 1, 64'h10,  64'h0,  32'h0,        0);
        add(1, 0, 64'h0,   64'h0,  32'h0,        0);
        add(0, 0, 64'h0,   64'h10, 32'hCB010000, 1);
        // fetch beyond the ROM returns zero but stays valid
        add(0, 1, 64'h100, 64'h0,  32'h0,        0);
        add(0, 0, 64'h0,   64'h100, 32'h0,       1);
        add(0, 0, 64'h0,   64'h104, 32'h0,       1);
        // last word of the address space wraps to zero
        add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 32'h0, 0);
        add(0, 0, 64'h0,   64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1);
        add(0, 0, 64'h0,   64'h0,  32'hF8400000, 1);
        add(0, 0, 64'h0,   64'h4,  32'hF8000000, 1);

        #2;
        check("reset_state", 64'h0, 32'h0, 1'b0);
        #10;
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            stall    = vecs[i].stall;
            pcsrc    = vecs[i].pcsrc;
            pcbranch = vecs[i].br;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].einstr, vecs[i].evalid);
        end

        // asynchronous reset between edges, mid-stall
        stall = 1'b1;
        pcsrc = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_immediate", 64'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 64'h0, 32'h0, 1'b0);
        stall   = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_pc0", 64'h0, 32'hF8400000, 1'b1);
        @(posedge clk);
        #1;
        check("restart_pc4", 64'h4, 32'hF8000000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LEGv8 core, directly upstream of the main decoder. It holds the PC and reads the instruction ROM. It registers the fetched word into the IF/ID pipeline register, whose bits [31:21] drive the decoder `Op` input. It supports load-use stalls from the hazard unit and flushes on taken branches resolved downstream.

## Interface
Parameters:
- `N`, 64, datapath/PC width.
- `IMEM_WORDS`, 64, instruction ROM depth in 32-bit words; power of two.

Ports:
- `clk`  in  1  single clock, all state rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Stall`  in  1  hazard unit: hold PC and IF/ID.
- `PCSrc`  in  1  taken-branch redirect, from downstream branch logic.
- `PCBranch`  in  N  redirect target.
- `IF_ID_pc`  out  N  PC of the registered instruction.
- `IF_ID_instr`  out  32  registered instruction; `[31:21]` feeds the decoder `Op` input.
- `IF_ID_valid`  out  1  1 = real instruction, 0 = bubble.

## Operation
- State: `pc` (N), IF/ID register `{IF_ID_pc, IF_ID_instr, IF_ID_valid}`.
- Fetch is combinational: `fetched = rom[pc[$clog2(IMEM_WORDS)+1:2]]`.
  - Any `pc` with nonzero bits above the index range returns `32'h0`.
  - `32'h0` decodes to the all-zero control default, so it is a harmless NOP.
- `pc[1:0]` is always 0. `PCBranch[1:0]` is discarded on load.
- Next-state priority at each edge:
  1. `PCSrc=1`: `pc <= {PCBranch[N-1:2],2'b00}`; IF/ID <= bubble (`instr=0`, `valid=0`, `pc=0`). This holds regardless of `Stall`.
  2. `Stall=1` (and `PCSrc=0`): `pc` and IF/ID hold.
  3. Otherwise: `pc <= pc + 4` (modulo 2^N, wraps to 0); IF/ID <= `{pc, fetched, 1}`.
- Sequential states, implicit in `{pc, IF_ID_valid}`:
  - RESET: valid=0.
  - RUN: valid=1 after the first unstalled edge.
  - BUBBLE: one cycle after a flush; returns to RUN on the next unstalled edge.
- Stall during BUBBLE keeps the bubble: valid stays 0 and instr stays 0.
- No internal counters beyond `pc`. No handshake with the ROM, which is always ready.

## Timing
- Reset (asynchronous assert on `reset_n` low, effective immediately without a clock):
  - `pc=0`, `IF_ID_pc=0`, `IF_ID_instr=0`, `IF_ID_valid=0`.
- Release: the first rising edge with `reset_n=1` and no stall/redirect loads `IF_ID = {0, rom[0], 1}` and sets `pc=4`.
- Latency: an instruction at address A appears on `IF_ID_instr` one edge after `pc==A`.
- Redirect penalty:
  - The edge sampling `PCSrc=1` inserts exactly one bubble.
  - The target instruction appears on the following edge.
  - Instructions already past IF/ID are the downstream flush logic's responsibility.
- `PCSrc` and `Stall` are sampled only at the edge. Both are combinational inputs with no internal registering.
- Reset asserted mid-stall or mid-flush overrides everything immediately.
- `pc = 2^N-4` unstalled: the next `pc` is 0, with no error flag.

## Structure
- Shared package `core_pkg`:
  - `localparam logic [31:0] NOP_INSTR = 32'h0`.
  - `typedef struct packed {logic [N-1:0] pc; logic [31:0] instr; logic valid;} if_id_t`. Use 64-bit PC in the package.
  - Opcode field slice constants `OP_MSB=31`, `OP_LSB=21`, shared with the decoder.
- Sub-module `imem`:
  - Parameter `IMEM_WORDS`, input address, 32-bit output.
  - Combinational ROM initialised from a constant array.
  - Out-of-range handling lives in `fetch_stage`, not `imem`.
- PC register and IF/ID register stay in `fetch_stage`, as a single `always_ff` with async reset.

## Test plan
- Reset then free run; ROM words 0..3 = `F8400000, F8000000, 8B000000, B4000000` -> IF_ID shows `(pc,instr)` = `(0,F8400000)`, `(4,F8000000)`, `(8,8B000000)`, `(C,B4000000)` on successive edges, valid=1 from the first edge.
- `Stall=1` for 3 cycles while `IF_ID_pc=8` -> IF_ID and `pc` unchanged for 3 edges; the next edge shows `pc=C`.
- `PCSrc=1`, `PCBranch=0x23` while `Stall=1` -> the next edge gives valid=0 and instr=0; the following edge gives `IF_ID_pc=0x20`, instr=`rom[8]`.
- Fetch at `pc=0x100` with `IMEM_WORDS=64` -> `IF_ID_instr=0`, valid=1, `pc` keeps incrementing.
- Force `pc` near wrap (ROM-less check via hierarchical init, `pc=FFFF_FFFF_FFFF_FFFC`) -> next `pc=0`, `IF_ID_pc=FFFF_FFFF_FFFF_FFFC`.
- Assert `reset_n=0` between edges mid-run -> all outputs 0 immediately, before the next edge; release -> restart at `pc=0`.
